// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared state type and round constants for the Ascon-128 sequencer
package ascon_pack;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_W_AD,
        ST_AD,
        ST_W_PT,
        ST_PT,
        ST_FINAL,
        ST_DONE
    } ctrl_state_t;

    localparam logic [3:0] ROUND_PA_START = 4'd0;
    localparam logic [3:0] ROUND_PB_START = 4'd6;
    localparam logic [3:0] ROUND_LAST     = 4'd11;

    // Width of a counter that must reach max(n_ad, n_pt)-1; never narrower than one bit.
    function automatic int blk_width(input int n_ad, input int n_pt);
        int m;
        m = (n_ad > n_pt) ? n_ad : n_pt;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/ascon_round_counter.sv
// rtl/ascon_round_counter.sv - 4-bit permutation round counter with load and saturating increment
module ascon_round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       load_i,
    input  logic [3:0] load_value_i,
    input  logic       enable_i,
    output logic [3:0] count_o,
    output logic       last_o
);

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            count_o <= 4'd0;
        end else if (load_i) begin
            count_o <= load_value_i;
        end else if (enable_i && (count_o != ROUND_LAST)) begin
            count_o <= count_o + 4'd1;
        end
    end

    assign last_o = (count_o == ROUND_LAST);

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// rtl/ascon_ctrl_fsm.sv - Ascon-128 encryption sequencer driving the permutation datapath
module ascon_ctrl_fsm
    import ascon_pack::*;
#(
    parameter int NUM_AD_BLOCKS = 1,
    parameter int NUM_PT_BLOCKS = 4
) (
    input  logic        clock_i,
    input  logic        resetb_i,
    input  logic        start_i,
    input  logic        data_valid_i,
    input  logic [63:0] data_i,
    output logic        data_ready_o,
    output logic [63:0] data_o,
    output logic [3:0]  round_o,
    output logic        enable_o,
    output logic        selectionp_o,
    output logic        bypass_begin_o,
    output logic        bypass_end_o,
    output logic        mode_int_ext_o,
    output logic        mode_init_data_o,
    output logic        en_cipher_o,
    output logic        en_tag_o,
    output logic        cipher_valid_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int BW = blk_width(NUM_AD_BLOCKS, NUM_PT_BLOCKS);
    localparam logic [BW-1:0] AD_LAST = BW'(NUM_AD_BLOCKS - 1);
    localparam logic [BW-1:0] PT_LAST = BW'(NUM_PT_BLOCKS - 1);
    localparam logic [BW-1:0] BLK_ONE = BW'(1);

    ctrl_state_t    state, nxt_state;
    logic [BW-1:0]  blk, nxt_blk;
    logic [3:0]     round, nxt_round, rc_value;
    logic           rc_load, rc_inc, rc_last, take;

    logic n_ready, n_enable, n_selp, n_bb, n_be, n_mie, n_mid, n_enc, n_tag;
    logic pb_first, fin_first, at_last;

    ascon_round_counter u_round (
        .clock_i      (clock_i),
        .resetb_i     (resetb_i),
        .load_i       (rc_load),
        .load_value_i (rc_value),
        .enable_i     (rc_inc),
        .count_o      (round),
        .last_o       (rc_last)
    );

    assign round_o = round;

    always_comb begin
        nxt_state = state;
        nxt_blk   = blk;
        rc_load   = 1'b0;
        rc_value  = ROUND_PA_START;
        rc_inc    = 1'b0;
        take      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    nxt_state = ST_INIT;
                    rc_load   = 1'b1;
                end
            end
            ST_INIT: begin
                if (rc_last) begin
                    nxt_state = ST_W_AD;
                    nxt_blk   = '0;
                end else begin
                    rc_inc = 1'b1;
                end
            end
            ST_W_AD: begin
                if (data_valid_i) begin
                    take      = 1'b1;
                    nxt_state = ST_AD;
                    rc_load   = 1'b1;
                    rc_value  = ROUND_PB_START;
                end
            end
            ST_AD: begin
                if (rc_last) begin
                    if (blk == AD_LAST) begin
                        nxt_state = ST_W_PT;
                        nxt_blk   = '0;
                    end else begin
                        nxt_state = ST_W_AD;
                        nxt_blk   = blk + BLK_ONE;
                    end
                end else begin
                    rc_inc = 1'b1;
                end
            end
            ST_W_PT: begin
                if (data_valid_i) begin
                    take    = 1'b1;
                    rc_load = 1'b1;
                    // The last plaintext block is folded into the finalization permutation.
                    if (blk == PT_LAST) begin
                        nxt_state = ST_FINAL;
                        rc_value  = ROUND_PA_START;
                    end else begin
                        nxt_state = ST_PT;
                        rc_value  = ROUND_PB_START;
                    end
                end
            end
            ST_PT: begin
                if (rc_last) begin
                    nxt_state = ST_W_PT;
                    nxt_blk   = blk + BLK_ONE;
                end else begin
                    rc_inc = 1'b1;
                end
            end
            ST_FINAL: begin
                if (rc_last) begin
                    nxt_state = ST_DONE;
                end else begin
                    rc_inc = 1'b1;
                end
            end
            ST_DONE:  nxt_state = ST_IDLE;
            default:  nxt_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state/round so they register in step with them.
    always_comb begin
        nxt_round = rc_load ? rc_value : (rc_inc ? round + 4'd1 : round);
        pb_first  = ((nxt_state == ST_AD) || (nxt_state == ST_PT)) && (nxt_round == ROUND_PB_START);
        fin_first = (nxt_state == ST_FINAL) && (nxt_round == ROUND_PA_START);
        at_last   = (nxt_round == ROUND_LAST);
        n_ready   = (nxt_state == ST_W_AD) || (nxt_state == ST_W_PT);
        n_enable  = (nxt_state == ST_INIT) || (nxt_state == ST_AD) ||
                    (nxt_state == ST_PT) || (nxt_state == ST_FINAL);
        n_selp    = (nxt_state != ST_IDLE) &&
                    !((nxt_state == ST_INIT) && (nxt_round == ROUND_PA_START));
        n_mid     = (nxt_state == ST_AD) && at_last && (nxt_blk == AD_LAST);
        n_tag     = (nxt_state == ST_FINAL) && at_last;
        n_be      = !(((nxt_state == ST_INIT) && at_last) || n_mid || n_tag);
        n_bb      = !(pb_first || fin_first);
        n_mie     = fin_first;
        n_enc     = ((nxt_state == ST_PT) && (nxt_round == ROUND_PB_START)) || fin_first;
    end

    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            state            <= ST_IDLE;
            blk              <= '0;
            data_o           <= '0;
            data_ready_o     <= 1'b0;
            enable_o         <= 1'b0;
            selectionp_o     <= 1'b0;
            bypass_begin_o   <= 1'b1;
            bypass_end_o     <= 1'b1;
            mode_int_ext_o   <= 1'b0;
            mode_init_data_o <= 1'b0;
            en_cipher_o      <= 1'b0;
            en_tag_o         <= 1'b0;
            cipher_valid_o   <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
        end else begin
            state            <= nxt_state;
            blk              <= nxt_blk;
            if (take) begin
                data_o <= data_i;
            end
            data_ready_o     <= n_ready;
            enable_o         <= n_enable;
            selectionp_o     <= n_selp;
            bypass_begin_o   <= n_bb;
            bypass_end_o     <= n_be;
            mode_int_ext_o   <= n_mie;
            mode_init_data_o <= n_mid;
            en_cipher_o      <= n_enc;
            en_tag_o         <= n_tag;
            cipher_valid_o   <= en_cipher_o;
            busy_o           <= (nxt_state != ST_IDLE);
            done_o           <= (nxt_state == ST_DONE);
        end
    end

endmodule
